// File: rtl/mem_controller.sv
// Wait-state memory controller: latches one read or write request, inserts
// WAIT_CYCLES wait states, accesses an internal 32-bit RAM, then pulses done.
module mem_controller #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        in_reset_n,
  input  logic [31:0] in_mar,
  input  logic [31:0] in_mdr,
  input  logic        in_read,
  input  logic        in_write,
  output logic [31:0] out_mem_data,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_error,
  output logic [1:0]  dbg_state
);

  // Request handshake: in_read/in_write are level-sampled only while IDLE
  // (out_busy=0); exactly one high starts an operation, and out_done pulses
  // for one cycle when it completes. Inputs are ignored while out_busy=1.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam int         DEPTH     = 1 << ADDR_BITS;

  logic [1:0]           state;
  logic [3:0]           wait_cnt;
  logic [31:0]          mar_q;
  logic [31:0]          mdr_q;
  logic                 write_q;
  logic [31:0]          mem [0:DEPTH-1];
  logic [ADDR_BITS-1:0] word_addr;
  logic                 out_of_range;
  logic                 req_one;
  logic                 req_both;

  assign word_addr    = mar_q[ADDR_BITS-1:0];
  assign out_of_range = |mar_q[31:ADDR_BITS];
  assign req_one      = in_read ^ in_write;
  assign req_both     = in_read & in_write;

  assign out_busy  = (state != S_IDLE);
  assign out_done  = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!in_reset_n) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      mar_q        <= 32'h0;
      mdr_q        <= 32'h0;
      write_q      <= 1'b0;
      out_mem_data <= 32'h0;
      out_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_both) begin
            out_error <= 1'b1;
          end else if (req_one) begin
            mar_q   <= in_mar;
            mdr_q   <= in_mdr;
            write_q <= in_write;
            if (WAIT_CYCLES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          state <= S_DONE;
          // Out-of-range addresses still complete, but flag and read as zero.
          if (out_of_range) begin
            out_error <= 1'b1;
            if (!write_q) out_mem_data <= 32'h0;
          end else if (!write_q) begin
            out_mem_data <= mem[word_addr];
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared; reset on the ACCESS edge blocks the write.
  always_ff @(posedge clk) begin
    if (in_reset_n && state == S_ACCESS && write_q && !out_of_range)
      mem[word_addr] <= mdr_q;
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: one instance with two wait states,
// one with none, sharing clock and reset.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        in_reset_n;
  logic [31:0] a_mar, a_mdr, b_mar, b_mdr;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_data, b_data;
  logic        a_busy, a_done, a_error, b_busy, b_done, b_error;
  logic [1:0]  a_state, b_state;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_controller #(.ADDR_BITS(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .in_reset_n(in_reset_n), .in_mar(a_mar), .in_mdr(a_mdr),
    .in_read(a_read), .in_write(a_write), .out_mem_data(a_data),
    .out_busy(a_busy), .out_done(a_done), .out_error(a_error), .dbg_state(a_state)
  );

  mem_controller #(.ADDR_BITS(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .in_reset_n(in_reset_n), .in_mar(b_mar), .in_mdr(b_mdr),
    .in_read(b_read), .in_write(b_write), .out_mem_data(b_data),
    .out_busy(b_busy), .out_done(b_done), .out_error(b_error), .dbg_state(b_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the two-wait-state instance: done only in cycle 4,
  // busy in cycles 1..4, idle in cycle 5. Optionally disturbs inputs mid-op.
  task automatic op_a(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic disturb, input string tag);
    a_mar = addr; a_mdr = data; a_read = ~wr; a_write = wr;
    step();
    a_read = 1'b0; a_write = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check({tag, "_busy"}, {31'h0, a_busy}, 32'h1);
      check({tag, "_done"}, {31'h0, a_done}, {31'h0, (c == 4)});
      if (disturb && c == 2) begin
        a_mar = 32'h5; a_mdr = 32'hBAD0BAD0;
      end
      step();
    end
    check({tag, "_idle"}, {31'h0, a_busy}, 32'h0);
  endtask

  initial begin
    in_reset_n = 1'b0;
    a_mar = 32'h0; a_mdr = 32'h0; a_read = 1'b0; a_write = 1'b0;
    b_mar = 32'h0; b_mdr = 32'h0; b_read = 1'b0; b_write = 1'b0;
    step();
    step();
    check("rst_busy",  {31'h0, a_busy},  32'h0);
    check("rst_done",  {31'h0, a_done},  32'h0);
    check("rst_error", {31'h0, a_error}, 32'h0);
    check("rst_data",  a_data,           32'h0);
    check("rst_state", {30'h0, a_state}, 32'h0);
    in_reset_n = 1'b1;
    step();

    // Write then read back, data must not move on the write.
    op_a(1'b1, 32'h5, 32'hDEADBEEF, 1'b0, "wr5");
    check("wr5_data_held", a_data, 32'h0);
    op_a(1'b0, 32'h5, 32'h0, 1'b0, "rd5");
    check("rd5_data", a_data, 32'hDEADBEEF);
    check("rd5_error", {31'h0, a_error}, 32'h0);

    op_a(1'b1, 32'h7, 32'h0A0A0A0A, 1'b0, "wr7");
    op_a(1'b0, 32'h7, 32'h0, 1'b0, "rd7");
    check("rd7_data", a_data, 32'h0A0A0A0A);

    // Reset during WAIT of a write to 7.
    a_mar = 32'h7; a_mdr = 32'h12345678; a_write = 1'b1;
    step();
    a_write = 1'b0;
    check("abort_in_wait", {30'h0, a_state}, 32'h1);
    in_reset_n = 1'b0;
    step();
    check("abort_busy",  {31'h0, a_busy},  32'h0);
    check("abort_done",  {31'h0, a_done},  32'h0);
    check("abort_error", {31'h0, a_error}, 32'h0);
    check("abort_data",  a_data,           32'h0);
    in_reset_n = 1'b1;
    step();
    op_a(1'b0, 32'h7, 32'h0, 1'b0, "rd7_after_abort");
    check("rd7_kept", a_data, 32'h0A0A0A0A);

    // Address/data changes while busy are ignored.
    op_a(1'b1, 32'h9, 32'h11112222, 1'b1, "wr9_disturb");
    op_a(1'b0, 32'h9, 32'h0, 1'b0, "rd9");
    check("rd9_data", a_data, 32'h11112222);
    op_a(1'b0, 32'h5, 32'h0, 1'b0, "rd5_again");
    check("rd5_untouched", a_data, 32'hDEADBEEF);

    // Held read gives back-to-back completions every 5 cycles.
    a_mar = 32'h9; a_read = 1'b1;
    step();
    for (int c = 1; c <= 10; c++) begin
      check("b2b_done", {31'h0, a_done}, {31'h0, (c == 4 || c == 9)});
      check("b2b_busy", {31'h0, a_busy}, {31'h0, (c != 5 && c != 10)});
      if (c == 9) a_read = 1'b0;
      step();
    end

    // Out-of-range write is suppressed, out-of-range read returns zero.
    op_a(1'b1, 32'h0, 32'h00000077, 1'b0, "wr0");
    check("wr0_error", {31'h0, a_error}, 32'h0);
    op_a(1'b1, 32'h200, 32'hCAFEF00D, 1'b0, "wr_oor");
    check("wr_oor_error", {31'h0, a_error}, 32'h1);
    op_a(1'b0, 32'h0, 32'h0, 1'b0, "rd0");
    check("rd0_data", a_data, 32'h00000077);
    op_a(1'b0, 32'h200, 32'h0, 1'b0, "rd_oor");
    check("rd_oor_data", a_data, 32'h0);
    check("error_sticky", {31'h0, a_error}, 32'h1);

    // Reset clears the error but not the RAM.
    in_reset_n = 1'b0;
    step();
    check("rst2_error", {31'h0, a_error}, 32'h0);
    in_reset_n = 1'b1;
    step();
    op_a(1'b0, 32'h0, 32'h0, 1'b0, "rd0_after_rst");
    check("ram_survives_rst", a_data, 32'h00000077);

    // Simultaneous read and write: error, no operation.
    a_mar = 32'h5; a_read = 1'b1; a_write = 1'b1;
    step();
    a_read = 1'b0; a_write = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("both_error", {31'h0, a_error}, 32'h1);
      check("both_busy",  {31'h0, a_busy},  32'h0);
      check("both_done",  {31'h0, a_done},  32'h0);
      step();
    end
    check("both_data_held", a_data, 32'h00000077);

    // Zero wait states: done in cycle 2, busy in cycles 1-2.
    b_mar = 32'h3; b_mdr = 32'h5A5A5A5A; b_write = 1'b1;
    step();
    b_write = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("w0_wr_busy", {31'h0, b_busy}, {31'h0, (c <= 2)});
      check("w0_wr_done", {31'h0, b_done}, {31'h0, (c == 2)});
      step();
    end
    b_read = 1'b1;
    step();
    b_read = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("w0_rd_busy", {31'h0, b_busy}, {31'h0, (c <= 2)});
      check("w0_rd_done", {31'h0, b_done}, {31'h0, (c == 2)});
      if (c == 2) check("w0_rd_data", b_data, 32'h5A5A5A5A);
      step();
    end
    check("w0_error", {31'h0, b_error}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
